// File: rtl/leb128_pkg.sv
// Shared constants, FSM state type and length helper for the signed-LEB128 i32 encoder.
// Imported by leb128_i32_step and pack_i32_stream.
package leb128_pkg;

    localparam int LEB128_I32_MAX_BYTES = 5;
    localparam int LEB128_GROUP_BITS    = 7;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_e;

    // Smallest k in 1..5 such that v fits in 7k signed bits.
    function automatic logic [2:0] leb128_i32_len(input logic [31:0] v);
        logic [2:0] len;
        len = 3'(LEB128_I32_MAX_BYTES);
        // Walk downwards so the smallest fitting width is the one that sticks.
        for (int k = LEB128_I32_MAX_BYTES - 1; k >= 1; k--) begin
            if ((($signed(v) >>> (LEB128_GROUP_BITS * k - 1)) == 32'sd0) ||
                (($signed(v) >>> (LEB128_GROUP_BITS * k - 1)) == -32'sd1)) begin
                len = 3'(k);
            end
        end
        return len;
    endfunction

endpackage

// File: rtl/leb128_i32_step.sv
// One signed-LEB128 encoding step: splits residual R into the next output byte,
// the arithmetically shifted remainder N and the terminating-byte flag.
module leb128_i32_step
    import leb128_pkg::*;
(
    input  logic [31:0] r_i,
    output logic [7:0]  byte_o,
    output logic [31:0] next_o,
    output logic        last_o
);

    logic [6:0] group;

    assign group  = r_i[6:0];
    assign next_o = $unsigned($signed(r_i) >>> LEB128_GROUP_BITS);

    // Stop once the remaining bits are pure sign extension of group bit 6.
    assign last_o = ((next_o == 32'h0000_0000) && !group[6]) ||
                    ((next_o == 32'hffff_ffff) &&  group[6]);

    assign byte_o = {~last_o, group};

endmodule

// File: rtl/pack_i32_stream.sv
// Streaming canonical signed-LEB128 encoder for 32-bit values, one byte per output handshake.
// Define PACK_I32_STREAM_BACK2BACK_EN to accept the next value while the last byte drains.
module pack_i32_stream
    import leb128_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_data,
    input  logic        i_valid,
    output logic        i_ready,
    output logic [7:0]  o_data,
    output logic        o_valid,
    input  logic        o_ready,
    output logic        o_last,
    output logic [2:0]  o_len
);

    state_e      state_q;
    logic [31:0] r_q;       // residual left after the byte currently on o_data
    logic [7:0]  o_data_q;
    logic        o_valid_q;
    logic        o_last_q;
    logic [2:0]  o_len_q;
    logic        i_ready_q;

    logic        o_fire;
    logic        accept;
    logic [31:0] step_in;
    logic [7:0]  step_byte;
    logic [31:0] step_next;
    logic        step_last;

    assign o_fire = o_valid_q && o_ready;

`ifdef PACK_I32_STREAM_BACK2BACK_EN
    assign i_ready = i_ready_q || (o_fire && o_last_q);
`else
    assign i_ready = i_ready_q;
`endif

    assign accept  = i_valid && i_ready;
    assign step_in = accept ? i_data : r_q;

    leb128_i32_step u_step (
        .r_i    (step_in),
        .byte_o (step_byte),
        .next_o (step_next),
        .last_o (step_last)
    );

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            o_data_q  <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_len_q   <= '0;
            i_ready_q <= 1'b0;
        end else if (accept) begin
            state_q   <= EMIT;
            r_q       <= step_next;
            o_data_q  <= step_byte;
            o_last_q  <= step_last;
            o_len_q   <= leb128_i32_len(i_data);
            o_valid_q <= 1'b1;
            i_ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: i_ready_q <= 1'b1;
                EMIT: begin
                    if (o_fire) begin
                        if (o_last_q) begin
                            state_q   <= IDLE;
                            o_valid_q <= 1'b0;
                            o_last_q  <= 1'b0;
                            i_ready_q <= 1'b1;
                        end else begin
                            r_q      <= step_next;
                            o_data_q <= step_byte;
                            o_last_q <= step_last;
                        end
                    end
                end
            endcase
        end
    end

    assign o_data  = o_data_q;
    assign o_valid = o_valid_q;
    assign o_last  = o_last_q;
    assign o_len   = o_len_q;

endmodule

// File: tb/tb_pack_i32_stream.sv
// Self-checking bench for pack_i32_stream: directed test-plan values, random values with
// random output stalls, back-to-back transfer and mid-sequence reset, against an arithmetic model.
module tb_pack_i32_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] i_data = '0;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [7:0]  o_data;
    logic        o_valid;
    logic        o_ready = 1'b0;
    logic        o_last;
    logic [2:0]  o_len;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pack_i32_stream dut (
        .clk     (clk),
        .rst     (rst),
        .i_data  (i_data),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_last  (o_last),
        .o_len   (o_len)
    );

    // Reference: length is the smallest k whose 7k-bit signed range holds v;
    // byte i is bits [7i+6:7i] of the sign-extended value with continuation on all but the last.
    function automatic int model_len(input logic [31:0] v);
        longint lv;
        int     len;
        lv  = longint'($signed(v));
        len = 5;
        for (int k = 4; k >= 1; k--) begin
            if (lv >= -(64'sd1 <<< (7 * k - 1)) && lv < (64'sd1 <<< (7 * k - 1)))
                len = k;
        end
        return len;
    endfunction

    function automatic logic [7:0] model_byte(input logic [31:0] v, input int i, input int k);
        longint lv;
        logic [6:0] g;
        lv = longint'($signed(v));
        g  = 7'((lv >>> (7 * i)) & 64'sh7f);
        return {(i < k - 1), g};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entry and exit point: 1 time unit after a falling edge.
    task automatic send(input logic [31:0] v, input bit stall);
        int k;
        int idx;
        int t;
        logic exp_rdy;
        k = model_len(v);
        i_data  = v;
        i_valid = 1'b1;
        o_ready = 1'b1;
        t = 0;
        while (!i_ready && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk("accept_wait", 32'(t < 20), 32'd1);
        @(negedge clk);
        i_valid = 1'b0;
        idx = 0;
        t   = 0;
        while (idx < k && t < 80) begin
            o_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
`ifdef PACK_I32_STREAM_BACK2BACK_EN
            exp_rdy = (idx == k - 1) && o_ready;
`else
            exp_rdy = 1'b0;
`endif
            chk("o_valid", o_valid, 1);
            chk("o_data", o_data, model_byte(v, idx, k));
            chk("o_last", o_last, 32'(idx == k - 1));
            chk("o_len", o_len, k);
            chk("i_ready_busy", i_ready, exp_rdy);
            if (o_ready) idx++;
            t++;
            @(negedge clk);
        end
        chk("emit_count", idx, k);
        o_ready = 1'b1;
        #1;
        chk("idle_o_valid", o_valid, 0);
        chk("idle_i_ready", i_ready, 1);
    endtask

    initial begin
        logic [31:0] v;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_last", o_last, 0);
        chk("rst_o_len", o_len, 0);
        chk("rst_i_ready", i_ready, 0);
        @(negedge clk);
        #1;
        chk("ready_after_reset", i_ready, 1);

        send(32'd0, 1'b0);
        send(-32'sd624485, 1'b0);
        send(-32'sd1, 1'b0);
        send(32'd63, 1'b0);
        send(32'd64, 1'b0);
        send(-32'sd64, 1'b0);
        send(-32'sd65, 1'b0);
        send(32'h7fff_ffff, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(-32'sd624485, 1'b1);
        send(-32'sd624485, 1'b1);

        // Two single-byte values offered back to back.
`ifdef PACK_I32_STREAM_BACK2BACK_EN
        i_data  = 32'd0;
        i_valid = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        i_data = 32'd1;
        #1;
        chk("b2b_first_valid", o_valid, 1);
        chk("b2b_first_data", o_data, model_byte(32'd0, 0, 1));
        chk("b2b_first_ready", i_ready, 1);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        chk("b2b_second_valid", o_valid, 1);
        chk("b2b_second_data", o_data, model_byte(32'd1, 0, 1));
        chk("b2b_second_last", o_last, 1);
        @(negedge clk);
        #1;
        chk("b2b_drained", o_valid, 0);
`else
        send(32'd0, 1'b0);
        send(32'd1, 1'b0);
`endif

        // Reset while the first of three bytes is stalled on the output.
        i_data  = -32'sd624485;
        i_valid = 1'b1;
        o_ready = 1'b0;
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        chk("pre_rst_valid", o_valid, 1);
        chk("pre_rst_data", o_data, model_byte(-32'sd624485, 0, 3));
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", o_valid, 0);
        chk("rst_mid_ready", i_ready, 0);
        o_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            #1;
            chk("post_rst_quiet", o_valid, 0);
            @(negedge clk);
        end
        #1;

        for (int n = 0; n < 40; n++) begin
            v = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) v = -v;
            send(v, 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
